inv_arb_2r: RTL and testbench
=============================

// Module: inv_arb_2r
// PURPOSE
//  Round-robin arbiter/sequencer sharing one WIDTH-bit conditional-invert unit between two requesters.
//  - Each requester presents operand + op bit over a valid/ready handshake.
//  - Result is O = In ^ {WIDTH{op}}.
//  - The result is registered and returned with the requester ID over a single response handshake.
//  - Sits between the decode/ALU-control stage and the shared inverter datapath.
// PARAMETERS
//  WIDTH    16   operand/result width in bits
//  CNT_W    16   width of the accepted-operation counter
// PORTS
//  clk          in   1      system clock; all state updates on the rising edge
//  rst          in   1      asynchronous, active-high reset
//  req0_valid   in   1      requester 0 holds a valid operand
//  req0_data    in   WIDTH  requester 0 operand
//  req0_op      in   1      requester 0: 1 = invert, 0 = pass
//  req0_ready   out  1      requester 0 operand accepted this cycle
//  req1_valid   in   1      requester 1 holds a valid operand
//  req1_data    in   WIDTH  requester 1 operand
//  req1_op      in   1      requester 1: 1 = invert, 0 = pass
//  req1_ready   out  1      requester 1 operand accepted this cycle
//  resp_valid   out  1      resp_data/resp_id hold a valid result
//  resp_id      out  1      requester that owns the result
//  resp_data    out  WIDTH  result
//  resp_ready   in   1      consumer takes the result this cycle
//  op_count     out  CNT_W  number of accepted operations, saturating
// BEHAVIOUR
//  - Reset (async): state=IDLE, resp_valid=0, resp_id=0, resp_data=0, op_count=0, rr_ptr=0.
//  - States: IDLE (output register empty), FULL (result held).
//  - slot_free = (state==IDLE) | (state==FULL & resp_ready).
//  - Arbitration (combinational):
//    - Only one valid: that requester wins.
//    - Both valid: rr_ptr wins (0 -> req0, 1 -> req1).
//    - reqN_ready = slot_free & (N is the winner).
//    - At most one ready is high per cycle.
//    - ready may depend combinationally on resp_ready and reqN_valid.
//  - Accept (reqN_valid & reqN_ready):
//    - Next edge: resp_data <= reqN_data ^ {WIDTH{reqN_op}}, resp_id <= N, resp_valid <= 1, state <= FULL.
//    - rr_ptr <= ~N, so the other requester has priority next.
//    - op_count <= op_count+1, saturating at all-ones.
//    - Latency: accept edge -> resp_valid high 1 cycle later; no bubble.
//  - FULL & resp_ready & no accept: resp_valid <= 0, state <= IDLE.
//  - FULL & resp_ready & accept: back-to-back; new result replaces old on the same edge, resp_valid stays 1.
//  - FULL & !resp_ready: resp_* held stable; both readys low (backpressure).
//  - No valid request: rr_ptr unchanged.
//  - Requesters must hold data/op stable while valid & !ready.
//  - rst mid-operation: any held result is discarded and op_count cleared immediately (async).
// CONFIGURATION
//  Macro INV_ARB_NEG_EN.
//  - Defined: adds ports req0_neg and req1_neg (in, 1).
//    - Accepted op=1 & neg=1 produces (~data)+1 mod 2^WIDTH (two's-complement negate).
//    - op=0 ignores neg.
//  - Undefined: neg ports absent; result is always data ^ {WIDTH{op}}.
// TESTING
//  1. rst=1 mid-FULL -> resp_valid=0, op_count=0, rr_ptr=0 immediately; first grant after release is req0 when both valid.
//  2. req0 valid data=16'h00FF op=1, resp_ready=1 -> req0_ready=1; next cycle resp_valid=1, resp_id=0, resp_data=16'hFF00.
//  3. Both valid every cycle, resp_ready=1 -> grants alternate 0,1,0,1; one result per cycle; op_count increments by 1 per cycle.
//  4. resp_ready=0 with result 16'h1234 held -> both readys low; resp_data stays 16'h1234 for 5 cycles; accept resumes the cycle resp_ready=1.
//  5. op_count preset near max (CNT_W=4, 15 accepts) -> 16th accept leaves op_count=4'hF.
//  6. INV_ARB_NEG_EN: req1 data=16'h0001 op=1 neg=1 -> resp_data=16'hFFFF; data=16'h0000 -> 16'h0000 (wrap).

Source files
------------

// File: rtl/inv_arb_2r.sv
`default_nettype none
// ============================================================================
// Module      : inv_arb_2r
// Description : Two-requester round-robin front end sharing a single registered
//               WIDTH-bit conditional-invert unit; result returned with owner ID.
//               Optional macro INV_ARB_NEG_EN adds a two's-complement negate mode.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_arb_2r #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_op,
`ifdef INV_ARB_NEG_EN
    input  logic             req0_neg,
`endif
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_op,
`ifdef INV_ARB_NEG_EN
    input  logic             req1_neg,
`endif
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    state_t           r_state;
    logic             r_rr_ptr;
    logic             r_resp_valid;
    logic             r_resp_id;
    logic [WIDTH-1:0] r_resp_data;
    logic [CNT_W-1:0] r_op_count;

    logic             w_slot_free;
    logic             w_grant1;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_op;
    logic             w_sel_neg;
    logic [WIDTH-1:0] w_result;

    // The slot frees up in the same cycle the consumer drains it, so a new
    // operand can be accepted back-to-back without a bubble.
    assign w_slot_free = (r_state == ST_IDLE) | ((r_state == ST_FULL) & resp_ready);
    assign w_grant1    = req1_valid & (~req0_valid | r_rr_ptr);
    assign w_accept    = w_slot_free & (req0_valid | req1_valid);

    assign req0_ready  = w_slot_free & req0_valid & ~w_grant1;
    assign req1_ready  = w_slot_free & w_grant1;

    always_comb begin
        w_sel_data = w_grant1 ? req1_data : req0_data;
        w_sel_op   = w_grant1 ? req1_op   : req0_op;
`ifdef INV_ARB_NEG_EN
        w_sel_neg  = w_grant1 ? req1_neg  : req0_neg;
`else
        w_sel_neg  = 1'b0;
`endif
        w_result   = w_sel_data ^ {WIDTH{w_sel_op}};
        if (w_sel_op & w_sel_neg) begin
            w_result = ~w_sel_data + c_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= 1'b0;
            r_resp_data  <= '0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state      <= ST_FULL;
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= w_grant1;
                        r_resp_data  <= w_result;
                        r_rr_ptr     <= ~w_grant1;
                        if (r_op_count != c_cnt_max) begin
                            r_op_count <= r_op_count + c_cnt_one;
                        end
                    end
                end
                ST_FULL: begin
                    if (w_accept) begin
                        r_state      <= ST_FULL;
                        r_resp_valid <= 1'b1;
                        r_resp_id    <= w_grant1;
                        r_resp_data  <= w_result;
                        r_rr_ptr     <= ~w_grant1;
                        if (r_op_count != c_cnt_max) begin
                            r_op_count <= r_op_count + c_cnt_one;
                        end
                    end else if (resp_ready) begin
                        r_state      <= ST_IDLE;
                        r_resp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_data  = r_resp_data;
    assign op_count   = r_op_count;

endmodule
`default_nettype wire

// File: tb/tb_inv_arb_2r.sv
`default_nettype none
// ============================================================================
// Module      : tb_inv_arb_2r
// Description : Randomized scoreboard bench for inv_arb_2r (small counter to
//               reach saturation); negate mode exercised when INV_ARB_NEG_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inv_arb_2r;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] data;
    } resp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [WIDTH-1:0] req0_data = '0;
    logic             req0_op = 1'b0;
    logic             req0_neg = 1'b0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [WIDTH-1:0] req1_data = '0;
    logic             req1_op = 1'b0;
    logic             req1_neg = 1'b0;
    logic             req1_ready;
    logic             resp_valid;
    logic             resp_id;
    logic [WIDTH-1:0] resp_data;
    logic             resp_ready = 1'b0;
    logic [CNT_W-1:0] op_count;

    int    n_vec = 0;
    int    n_err = 0;
    resp_t sb_q[$];

    // Reference state: is the output slot occupied, who has priority, how many accepts.
    bit m_full = 1'b0;
    bit m_prio = 1'b0;
    int m_cnt  = 0;
    bit acc0   = 1'b0;
    bit acc1   = 1'b0;

    always #5 clk = ~clk;

    inv_arb_2r #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_op    (req0_op),
`ifdef INV_ARB_NEG_EN
        .req0_neg   (req0_neg),
`endif
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_op    (req1_op),
`ifdef INV_ARB_NEG_EN
        .req1_neg   (req1_neg),
`endif
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready),
        .op_count   (op_count)
    );

    function automatic logic [WIDTH-1:0] expect_result(logic [WIDTH-1:0] d, logic op, logic neg);
        int unsigned v;
        v = d;
`ifdef INV_ARB_NEG_EN
        if (op && neg) return WIDTH'((1 << WIDTH) - v);
`endif
        if (op) return WIDTH'(((1 << WIDTH) - 1) - v);
        return d;
    endfunction

    task automatic check(string name, longint act, longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: predicts grants and pushes expected responses.
    always @(negedge clk) begin
        bit slot_free, win1, accept;
        if (rst) begin
            m_full = 1'b0;
            m_prio = 1'b0;
            m_cnt  = 0;
            acc0   = 1'b0;
            acc1   = 1'b0;
            sb_q.delete();
        end else begin
            check("resp_valid", resp_valid, m_full);
            check("op_count", op_count, m_cnt);
            slot_free = !m_full || resp_ready;
            win1      = req1_valid && (!req0_valid || m_prio);
            accept    = slot_free && (req0_valid || req1_valid);
            check("req0_ready", req0_ready, accept && !win1);
            check("req1_ready", req1_ready, accept && win1);
            acc0 = accept && !win1;
            acc1 = accept && win1;
            if (accept) begin
                resp_t r;
                r.id   = win1;
                r.data = win1 ? expect_result(req1_data, req1_op, req1_neg)
                              : expect_result(req0_data, req0_op, req0_neg);
                sb_q.push_back(r);
                m_prio = !win1;
                m_full = 1'b1;
                if (m_cnt < CNT_MAX) m_cnt++;
            end else if (resp_ready) begin
                m_full = 1'b0;
            end
        end
    end

    // Monitor: compares the presented result against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && resp_valid) begin
            if (sb_q.size() == 0) begin
                check("resp_unexpected", 1, 0);
            end else begin
                check("resp_id", resp_id, sb_q[0].id);
                check("resp_data", resp_data, sb_q[0].data);
                if (resp_ready) void'(sb_q.pop_front());
            end
        end
    end

    task automatic drive_random(int p_valid);
        if (!req0_valid || acc0) begin
            req0_valid = ($urandom_range(0, 99) < p_valid);
            req0_data  = WIDTH'($urandom);
            req0_op    = 1'($urandom);
            req0_neg   = 1'($urandom);
        end
        if (!req1_valid || acc1) begin
            req1_valid = ($urandom_range(0, 99) < p_valid);
            req1_data  = WIDTH'($urandom);
            req1_op    = 1'($urandom);
            req1_neg   = 1'($urandom);
        end
        resp_ready = ($urandom_range(0, 3) != 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_op_count", op_count, 0);
        rst = 1'b0;

        // Directed: single invert through an idle slot.
        req0_valid = 1'b1; req0_data = 16'h00FF; req0_op = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        check("dir_invert_data", resp_data, 16'hFF00);

        // Directed: both always valid, consumer always ready.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            req0_valid = 1'b1; req0_data = WIDTH'($urandom); req0_op = 1'($urandom);
            req1_valid = 1'b1; req1_data = WIDTH'($urandom); req1_op = 1'($urandom);
            resp_ready = 1'b1;
        end

        // Directed: backpressure holds a result for several cycles.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_data = 16'hEDCB; req0_op = 1'b1;
        req1_valid = 1'b1; req1_data = 16'h1234; req1_op = 1'b0;
        resp_ready = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;

        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            drive_random(i < 300 ? 75 : 40);
        end

        // Asynchronous reset while a result is held.
        @(posedge clk); #1;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", resp_valid, 0);
        check("async_rst_count", op_count, 0);
        req0_data = 16'h0F0F; req0_op = 1'b1;
        req1_data = 16'h5555; req1_op = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_first_id", resp_id, 0);
        req0_valid = 1'b0;

        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            drive_random(60);
        end

        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("drain_queue_empty", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
